// File: rtl/uart_rx_loader.sv
// Packet loader behind the UART receiver: parses SYNC/CMD framed packets, streams WRITE
// payloads into RAM over a req/ack port and releases the CPU hold on a good RUN packet.
module uart_rx_loader #(
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 1000000,
  parameter int unsigned TIMER_WIDTH  = 20
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Mem_Wr,
  output logic [15:0] o_Mem_Addr,
  output logic [7:0]  o_Mem_Data,
  input  logic        i_Mem_Ack,
  output logic        o_Cpu_Hold,
  output logic        o_Done,
  output logic        o_Error,
  output logic [1:0]  o_Err_Code
);

  localparam logic [TIMER_WIDTH-1:0] TimeoutLast = TIMER_WIDTH'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddrHi, StAddrLo, StLen, StData, StCsum
  } state_e;

  state_e                 state_q, state_d;
  logic [15:0]            base_q, base_d;
  logic [15:0]            addr_q, addr_d;
  logic [7:0]             data_q, data_d;
  logic [7:0]             sum_q, sum_d;
  logic [8:0]             len_q, len_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic                   first_q, first_d;
  logic                   run_q, run_d;
  logic                   wr_q, wr_d;
  logic                   hold_q, hold_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [1:0]             code_q, code_d;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sum_d   = sum_q;
    len_d   = len_q;
    first_d = first_q;
    run_d   = run_q;
    wr_d    = wr_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    code_d  = code_q;
    timer_d = (i_Rx_DV || state_q == StIdle) ? '0 : timer_q + TIMER_WIDTH'(1);

    if (wr_q && i_Mem_Ack) begin
      wr_d   = 1'b0;
      addr_d = addr_q + 16'd1;
    end

    if (i_Rx_DV) begin
      unique case (state_q)
        StIdle: begin
          if (i_Rx_Byte == SYNC_BYTE) state_d = StCmd;
        end
        StCmd: begin
          sum_d = i_Rx_Byte;
          if (i_Rx_Byte == 8'h01) begin
            state_d = StAddrHi;
            hold_d  = 1'b1;
            run_d   = 1'b0;
          end else if (i_Rx_Byte == 8'h02) begin
            state_d = StCsum;
            run_d   = 1'b1;
          end else begin
            state_d = StIdle;
            error_d = 1'b1;
            code_d  = 2'd1;
          end
        end
        StAddrHi: begin
          base_d[15:8] = i_Rx_Byte;
          sum_d        = sum_q + i_Rx_Byte;
          state_d      = StAddrLo;
        end
        StAddrLo: begin
          base_d[7:0] = i_Rx_Byte;
          sum_d       = sum_q + i_Rx_Byte;
          state_d     = StLen;
        end
        StLen: begin
          len_d   = (i_Rx_Byte == 8'h00) ? 9'd256 : {1'b0, i_Rx_Byte};
          sum_d   = sum_q + i_Rx_Byte;
          first_d = 1'b1;
          state_d = StData;
        end
        StData: begin
          if (wr_q) begin
            state_d = StIdle;
            error_d = 1'b1;
            code_d  = 2'd3;
          end else begin
            // o_Mem_Addr is only retargeted here, when no write is outstanding.
            if (first_q) addr_d = base_q;
            first_d = 1'b0;
            data_d  = i_Rx_Byte;
            wr_d    = 1'b1;
            sum_d   = sum_q + i_Rx_Byte;
            len_d   = len_q - 9'd1;
            if (len_q == 9'd1) state_d = StCsum;
          end
        end
        StCsum: begin
          state_d = StIdle;
          error_d = 1'b1;
          if (wr_q) begin
            code_d = 2'd3;
          end else if (i_Rx_Byte == sum_q) begin
            error_d = 1'b0;
            done_d  = 1'b1;
            if (run_q) hold_d = 1'b0;
          end else begin
            code_d = 2'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && timer_q == TimeoutLast) begin
      state_d = StIdle;
      error_d = 1'b1;
      code_d  = 2'd2;
      timer_d = '0;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= StIdle;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      len_q   <= '0;
      timer_q <= '0;
      first_q <= 1'b0;
      run_q   <= 1'b0;
      wr_q    <= 1'b0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      len_q   <= len_d;
      timer_q <= timer_d;
      first_q <= first_d;
      run_q   <= run_d;
      wr_q    <= wr_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
      code_q  <= code_d;
    end
  end

  assign o_Mem_Wr   = wr_q;
  assign o_Mem_Addr = addr_q;
  assign o_Mem_Data = data_q;
  assign o_Cpu_Hold = hold_q;
  assign o_Done     = done_q;
  assign o_Error    = error_q;
  assign o_Err_Code = code_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Self-checking bench for uart_rx_loader: packet-level reference model compared every cycle,
// plus directed packets with hand-computed outcomes.
module tb_uart_rx_loader;

  localparam int          T    = 40;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_Rx_DV;
  logic [7:0]  i_Rx_Byte;
  logic        o_Mem_Wr;
  logic [15:0] o_Mem_Addr;
  logic [7:0]  o_Mem_Data;
  logic        i_Mem_Ack;
  logic        o_Cpu_Hold;
  logic        o_Done;
  logic        o_Error;
  logic [1:0]  o_Err_Code;

  uart_rx_loader #(
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CLKS(T),
    .TIMER_WIDTH (8)
  ) dut (
    .i_Clock   (clk),
    .i_Reset   (rst),
    .i_Rx_DV   (i_Rx_DV),
    .i_Rx_Byte (i_Rx_Byte),
    .o_Mem_Wr  (o_Mem_Wr),
    .o_Mem_Addr(o_Mem_Addr),
    .o_Mem_Data(o_Mem_Data),
    .i_Mem_Ack (i_Mem_Ack),
    .o_Cpu_Hold(o_Cpu_Hold),
    .o_Done    (o_Done),
    .o_Error   (o_Error),
    .o_Err_Code(o_Err_Code)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: tracks the packet as a byte queue and derives outputs from its contents.
  logic       in_pkt = 1'b0;
  logic [7:0] pkt[$];
  logic       m_wr = 1'b0, m_busy = 1'b0, m_hold = 1'b1, m_done = 1'b0, m_err = 1'b0;
  logic [1:0] m_code = 2'd0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_data = '0;
  int          quiet = 0;

  function automatic void abort(input logic [1:0] c);
    m_err  = 1'b1;
    m_code = c;
    in_pkt = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int n, len, sum;
    quiet = 0;
    if (!in_pkt) begin
      if (b == SYNC) begin
        in_pkt = 1'b1;
        pkt.delete();
      end
      return;
    end
    n = pkt.size();
    if (n == 0) begin
      if (b == 8'h01) m_hold = 1'b1;
      else if (b != 8'h02) begin
        abort(2'd1);
        return;
      end
      pkt.push_back(b);
      return;
    end
    if (pkt[0] == 8'h01 && n < 4) begin
      pkt.push_back(b);
      return;
    end
    if (m_busy) begin
      abort(2'd3);
      return;
    end
    len = (pkt[0] == 8'h02) ? 0 : ((pkt[3] == 8'h00) ? 256 : int'(pkt[3]));
    if (pkt[0] == 8'h01 && n < 4 + len) begin
      m_wr   = 1'b1;
      m_data = b;
      m_addr = {pkt[1], pkt[2]} + 16'(n - 4);
      pkt.push_back(b);
      return;
    end
    sum = 0;
    foreach (pkt[i]) sum += int'(pkt[i]);
    if (b == sum[7:0]) begin
      m_done = 1'b1;
      if (pkt[0] == 8'h02) m_hold = 1'b0;
    end else begin
      m_err  = 1'b1;
      m_code = 2'd0;
    end
    in_pkt = 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_pkt = 1'b0;
      pkt.delete();
      m_wr = 1'b0; m_busy = 1'b0; m_hold = 1'b1; m_done = 1'b0; m_err = 1'b0;
      m_code = 2'd0; m_addr = '0; m_data = '0; quiet = 0;
    end else begin
      m_busy = m_wr;
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_wr && i_Mem_Ack) m_wr = 1'b0;
      if (i_Rx_DV) model_byte(i_Rx_Byte);
      else if (in_pkt) begin
        quiet++;
        if (quiet == T) abort(2'd2);
      end
    end
  end

  always @(negedge clk) begin
    chk("mem_wr", 32'(o_Mem_Wr), 32'(m_wr));
    if (m_wr) begin
      chk("mem_addr", 32'(o_Mem_Addr), 32'(m_addr));
      chk("mem_data", 32'(o_Mem_Data), 32'(m_data));
    end
    chk("cpu_hold", 32'(o_Cpu_Hold), 32'(m_hold));
    chk("done", 32'(o_Done), 32'(m_done));
    chk("error", 32'(o_Error), 32'(m_err));
    chk("err_code", 32'(o_Err_Code), 32'(m_code));
  end

  // Event log for the directed checks.
  int          done_cnt = 0, err_cnt = 0;
  logic [1:0]  last_code = 2'd0;
  logic [23:0] wlog[$];

  always @(negedge clk) begin
    if (o_Done) done_cnt++;
    if (o_Error) begin
      err_cnt++;
      last_code = o_Err_Code;
    end
    if (o_Mem_Wr && i_Mem_Ack) wlog.push_back({o_Mem_Addr, o_Mem_Data});
  end

  function automatic logic [31:0] wl(input int i);
    return (i < wlog.size()) ? 32'(wlog[i]) : 32'hDEAD_BEEF;
  endfunction

  // RAM responder: acks ack_delay clocks after it first sees a request.
  logic ack_en = 1'b1;
  int   ack_delay = 2;
  int   wait_cnt = 0;
  initial begin
    i_Mem_Ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_Mem_Ack = 1'b0;
      if (o_Mem_Wr && ack_en) begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          i_Mem_Ack = 1'b1;
          wait_cnt  = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    tick();
    i_Rx_DV = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_pkt(input logic [7:0] bytes[$], input int gap);
    foreach (bytes[i]) send(bytes[i], gap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  int d0, e0, w0;

  initial begin
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_wr", 32'(o_Mem_Wr), 32'd0);
    chk("rst_hold", 32'(o_Cpu_Hold), 32'd1);
    chk("rst_addr", 32'(o_Mem_Addr), 32'd0);
    chk("rst_code", 32'(o_Err_Code), 32'd0);

    // RUN with correct checksum releases the CPU.
    d0 = done_cnt;
    send_pkt('{8'hA5, 8'h02, 8'h02}, 4);
    chk("run_done", 32'(done_cnt - d0), 32'd1);
    chk("run_hold", 32'(o_Cpu_Hold), 32'd0);
    chk("run_nowr", 32'(wlog.size()), 32'd0);

    // WRITE two bytes; checksum 01+12+34+02+AA+55 = 0x48.
    d0 = done_cnt;
    send_pkt('{8'hA5, 8'h01, 8'h12, 8'h34, 8'h02, 8'hAA, 8'h55, 8'h48}, 4);
    chk("wr_cnt", 32'(wlog.size()), 32'd2);
    chk("wr0", wl(0), 32'h1234AA);
    chk("wr1", wl(1), 32'h123555);
    chk("wr_done", 32'(done_cnt - d0), 32'd1);
    chk("wr_hold", 32'(o_Cpu_Hold), 32'd1);

    // Same packet, bad checksum: writes still land, error code 0.
    d0 = done_cnt; e0 = err_cnt;
    send_pkt('{8'hA5, 8'h01, 8'h12, 8'h34, 8'h02, 8'hAA, 8'h55, 8'h49}, 4);
    chk("bad_wr_cnt", 32'(wlog.size()), 32'd4);
    chk("bad_err", 32'(err_cnt - e0), 32'd1);
    chk("bad_code", 32'(last_code), 32'd0);
    chk("bad_nodone", 32'(done_cnt - d0), 32'd0);

    // Address wrap FFFF -> 0000; checksum 0x34.
    d0 = done_cnt;
    send_pkt('{8'hA5, 8'h01, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22, 8'h34}, 4);
    chk("wrap0", wl(4), 32'hFFFF11);
    chk("wrap1", wl(5), 32'h000022);
    chk("wrap_done", 32'(done_cnt - d0), 32'd1);

    // Unknown command.
    e0 = err_cnt;
    send_pkt('{8'hA5, 8'h07}, 4);
    chk("cmd_err", 32'(err_cnt - e0), 32'd1);
    chk("cmd_code", 32'(last_code), 32'd1);

    // Inter-byte timeout, then a fresh RUN is accepted.
    e0 = err_cnt;
    send_pkt('{8'hA5, 8'h01, 8'h00, 8'h10}, 0);
    repeat (T + 10) tick();
    chk("to_err", 32'(err_cnt - e0), 32'd1);
    chk("to_code", 32'(last_code), 32'd2);
    d0 = done_cnt;
    send_pkt('{8'hA5, 8'h02, 8'h02}, 4);
    chk("to_run_done", 32'(done_cnt - d0), 32'd1);

    // Overrun: second data byte arrives while the first write is still unacked.
    ack_en = 1'b0;
    e0 = err_cnt; w0 = wlog.size();
    send_pkt('{8'hA5, 8'h01, 8'h20, 8'h00, 8'h02}, 4);
    send(8'h11, 1);
    send(8'h22, 4);
    chk("ovr_code", 32'(last_code), 32'd3);
    chk("ovr_pending", 32'(o_Mem_Wr), 32'd1);
    chk("ovr_addr", 32'(o_Mem_Addr), 32'h2000);
    // SYNC accepted while the write is pending; the RUN checksum byte overruns again.
    send_pkt('{8'hA5, 8'h02, 8'h02}, 2);
    chk("ovr2_err", 32'(err_cnt - e0), 32'd2);
    ack_en = 1'b1;
    repeat (6) tick();
    chk("ovr_wr_cnt", 32'(wlog.size() - w0), 32'd1);
    chk("ovr_wr", wl(w0), 32'h200011);

    // Asynchronous reset during DATA with a write outstanding.
    ack_en = 1'b0;
    w0 = wlog.size();
    send_pkt('{8'hA5, 8'h01, 8'h30, 8'h00, 8'h03, 8'h5A}, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_wr", 32'(o_Mem_Wr), 32'd0);
    chk("arst_addr", 32'(o_Mem_Addr), 32'd0);
    chk("arst_data", 32'(o_Mem_Data), 32'd0);
    chk("arst_hold", 32'(o_Cpu_Hold), 32'd1);
    chk("arst_code", 32'(o_Err_Code), 32'd0);
    tick();
    rst = 1'b0;
    ack_en = 1'b1;
    d0 = done_cnt;
    send_pkt('{8'hA5, 8'h02, 8'h02}, 4);
    chk("arst_run", 32'(done_cnt - d0), 32'd1);
    chk("arst_nowr", 32'(wlog.size() - w0), 32'd0);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
